// File: rtl/mmio_timer_bank_if.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_timer_bank_if
//  Description : CPU data-bus bundle for the memory-mapped timer bank.
//                The master drives strobes, address and write data. The slave
//                returns combinational read data.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mmio_timer_bank_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rd, output wr, output addr, output wdata, input  rdata);
  modport slave  (input  rd, input  wr, input  addr, input  wdata, output rdata);
endinterface
`default_nettype wire

// File: rtl/mmio_timer_bank.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_timer_bank
//  Description : N_CH prescaled timers with reload, auto-reload or one-shot
//                mode, a sticky write-1-to-clear interrupt status register,
//                and LED, switch and 7-segment digit registers, all on the
//                CPU data bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module mmio_timer_bank #(
  parameter logic [31:0] BASE   = 32'h4000_0000,
  parameter int          N_CH   = 4,
  parameter int          CNT_W  = 32,
  parameter int          LED_W  = 8,
  parameter int          SW_W   = 8,
  parameter int          DIGI_W = 12
) (
  input  wire               clk,
  input  wire               reset,
  mmio_timer_bank_if.slave  bus,
  output logic [LED_W-1:0]  led,
  input  wire  [SW_W-1:0]   switch,
  output logic [DIGI_W-1:0] digi,
  output logic              irqout
);

  localparam logic [31:0]      c_CH_SPAN  = 32'(16 * N_CH);
  localparam logic [27:0]      c_SYS_BLK  = 28'h010;   // offsets 0x100..0x10F
  localparam logic [1:0]       c_R_RELOAD = 2'd0;
  localparam logic [1:0]       c_R_COUNT  = 2'd1;
  localparam logic [1:0]       c_R_CTRL   = 2'd2;
  localparam logic [1:0]       c_R_PRESC  = 2'd3;
  localparam logic [1:0]       c_R_STAT   = 2'd0;
  localparam logic [1:0]       c_R_LED    = 2'd1;
  localparam logic [1:0]       c_R_SW     = 2'd2;
  localparam logic [1:0]       c_R_DIGI   = 2'd3;
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [N_CH-1:0][CNT_W-1:0] reload_q, reload_d;
  logic [N_CH-1:0][CNT_W-1:0] count_q,  count_d;
  logic [N_CH-1:0][15:0]      presc_q,  presc_d;
  logic [N_CH-1:0][15:0]      pcnt_q,   pcnt_d;
  logic [N_CH-1:0]            en_q,     en_d;
  logic [N_CH-1:0]            ie_q,     ie_d;
  logic [N_CH-1:0]            os_q,     os_d;
  logic [N_CH-1:0]            stat_q,   stat_d;
  logic [LED_W-1:0]           led_q,    led_d;
  logic [DIGI_W-1:0]          digi_q,   digi_d;
  logic [SW_W-1:0]            sw_meta_q;
  logic [SW_W-1:0]            sw_sync_q;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic [31:0] w_off;
  logic        w_above;
  logic        w_aligned;
  logic        w_ch_hit;
  logic        w_sys_hit;
  logic [3:0]  w_ch_idx;
  logic [1:0]  w_reg;

  // Offsets are only meaningful at or above BASE; unaligned accesses miss.
  assign w_off     = bus.addr - BASE;
  assign w_above   = (bus.addr >= BASE);
  assign w_aligned = (w_off[1:0] == 2'b00);
  assign w_ch_hit  = w_above && w_aligned && (w_off < c_CH_SPAN);
  assign w_sys_hit = w_above && w_aligned && (w_off[31:4] == c_SYS_BLK);
  assign w_ch_idx  = w_off[7:4];
  assign w_reg     = w_off[3:2];

  logic [N_CH-1:0] w_wr_reload, w_wr_count, w_wr_ctrl, w_wr_presc;
  logic            w_wr_stat, w_wr_led, w_wr_digi;

  // Per-channel write strobes.
  always_comb begin
    w_wr_reload = '0;
    w_wr_count  = '0;
    w_wr_ctrl   = '0;
    w_wr_presc  = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (bus.wr && w_ch_hit && (w_ch_idx == 4'(c))) begin
        w_wr_reload[c] = (w_reg == c_R_RELOAD);
        w_wr_count[c]  = (w_reg == c_R_COUNT);
        w_wr_ctrl[c]   = (w_reg == c_R_CTRL);
        w_wr_presc[c]  = (w_reg == c_R_PRESC);
      end
    end
  end

  // SWITCH is read-only, so it gets no strobe.
  assign w_wr_stat = bus.wr && w_sys_hit && (w_reg == c_R_STAT);
  assign w_wr_led  = bus.wr && w_sys_hit && (w_reg == c_R_LED);
  assign w_wr_digi = bus.wr && w_sys_hit && (w_reg == c_R_DIGI);

  // --------------------------------------------------------------------------
  // Timer events
  // --------------------------------------------------------------------------
  logic [N_CH-1:0] w_tick, w_ovf, w_irq_set;

  // A bus write to COUNT suppresses the tick's effect, including overflow.
  always_comb begin
    w_tick    = '0;
    w_ovf     = '0;
    w_irq_set = '0;
    for (int c = 0; c < N_CH; c++) begin
      w_tick[c]    = en_q[c] && (pcnt_q[c] == presc_q[c]);
      w_ovf[c]     = w_tick[c] && (count_q[c] == c_CNT_MAX) && !w_wr_count[c];
      w_irq_set[c] = w_ovf[c] && ie_q[c];
    end
  end

  // Channel next state: bus writes take priority over timer activity.
  always_comb begin
    reload_d = reload_q;
    count_d  = count_q;
    presc_d  = presc_q;
    pcnt_d   = pcnt_q;
    en_d     = en_q;
    ie_d     = ie_q;
    os_d     = os_q;
    for (int c = 0; c < N_CH; c++) begin
      if (w_wr_reload[c]) reload_d[c] = bus.wdata[CNT_W-1:0];
      if (w_wr_presc[c])  presc_d[c]  = bus.wdata[15:0];

      // Prescaler restarts on any reconfiguration, while disabled, or on tick.
      if (w_wr_ctrl[c] || w_wr_presc[c] || !en_q[c] || w_tick[c])
        pcnt_d[c] = '0;
      else
        pcnt_d[c] = pcnt_q[c] + 16'd1;

      if (w_wr_count[c])
        count_d[c] = bus.wdata[CNT_W-1:0];
      else if (w_ovf[c])
        count_d[c] = reload_q[c];
      else if (w_tick[c])
        count_d[c] = count_q[c] + c_CNT_ONE;

      if (w_wr_ctrl[c]) begin
        en_d[c] = bus.wdata[0];
        ie_d[c] = bus.wdata[1];
        os_d[c] = bus.wdata[2];
      end else if (w_ovf[c] && os_q[c]) begin
        en_d[c] = 1'b0;
      end
    end
  end

  // Status next state: a new overflow beats a simultaneous clear.
  always_comb begin
    stat_d = stat_q;
    if (w_wr_stat) stat_d = stat_d & ~bus.wdata[N_CH-1:0];
    stat_d = stat_d | w_irq_set;
  end

  // LED and digit registers take the low bits of a write.
  always_comb begin
    led_d  = led_q;
    digi_d = digi_q;
    if (w_wr_led)  led_d  = bus.wdata[LED_W-1:0];
    if (w_wr_digi) digi_d = bus.wdata[DIGI_W-1:0];
  end

  // Register update for timers, status and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reload_q <= '0;
      count_q  <= '0;
      presc_q  <= '0;
      pcnt_q   <= '0;
      en_q     <= '0;
      ie_q     <= '0;
      os_q     <= '0;
      stat_q   <= '0;
      led_q    <= '0;
      digi_q   <= '0;
    end else begin
      reload_q <= reload_d;
      count_q  <= count_d;
      presc_q  <= presc_d;
      pcnt_q   <= pcnt_d;
      en_q     <= en_d;
      ie_q     <= ie_d;
      os_q     <= os_d;
      stat_q   <= stat_d;
      led_q    <= led_d;
      digi_q   <= digi_d;
    end
  end

  // Two-flop synchronizer for the asynchronous switch inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= switch;
      sw_sync_q <= sw_meta_q;
    end
  end

  // --------------------------------------------------------------------------
  // Read mux
  // --------------------------------------------------------------------------
  logic [31:0] w_rdata;

  // Side-effect-free read; misses and idle cycles return zero.
  always_comb begin
    w_rdata = '0;
    if (bus.rd && w_ch_hit) begin
      for (int c = 0; c < N_CH; c++) begin
        if (w_ch_idx == 4'(c)) begin
          case (w_reg)
            c_R_RELOAD: w_rdata = 32'(reload_q[c]);
            c_R_COUNT:  w_rdata = 32'(count_q[c]);
            c_R_CTRL:   w_rdata = {29'd0, os_q[c], ie_q[c], en_q[c]};
            default:    w_rdata = {16'd0, presc_q[c]};
          endcase
        end
      end
    end else if (bus.rd && w_sys_hit) begin
      case (w_reg)
        c_R_STAT: w_rdata = 32'(stat_q);
        c_R_LED:  w_rdata = 32'(led_q);
        c_R_SW:   w_rdata = 32'(sw_sync_q);
        default:  w_rdata = 32'(digi_q);
      endcase
    end
  end

  assign bus.rdata = w_rdata;
  assign led       = led_q;
  assign digi      = digi_q;
  assign irqout    = |stat_q;

endmodule
`default_nettype wire

// File: tb/tb_mmio_timer_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmio_timer_bank
//  Description : Self-checking bench for mmio_timer_bank. Expected values are
//                queued when stimulus is applied and popped when compared.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_timer_bank;

  localparam logic [31:0] BASE   = 32'h4000_0000;
  localparam logic [31:0] A_STAT = BASE + 32'h100;
  localparam logic [31:0] A_LED  = BASE + 32'h104;
  localparam logic [31:0] A_SW   = BASE + 32'h108;
  localparam logic [31:0] A_DIGI = BASE + 32'h10C;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  sw    = 8'h00;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irqout;

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got;
  logic [31:0] e;

  mmio_timer_bank_if bus_if ();

  mmio_timer_bank #(
    .BASE   (BASE),
    .N_CH   (4),
    .CNT_W  (32),
    .LED_W  (8),
    .SW_W   (8),
    .DIGI_W (12)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus_if),
    .led    (led),
    .switch (sw),
    .digi   (digi),
    .irqout (irqout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] ch_addr(input int c, input int r);
    return BASE + 32'(16 * c + 4 * r);
  endfunction

  // Called at a negedge; the write lands on the next posedge, returns at negedge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus_if.wr    = 1'b1;
    bus_if.addr  = a;
    bus_if.wdata = d;
    @(negedge clk);
    bus_if.wr    = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus_if.rd   = 1'b1;
    bus_if.addr = a;
    #1;
    d = bus_if.rdata;
    bus_if.rd   = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    e = exp_q.pop_front(); vectors++;
    if (32'(irqout) !== e) begin $display("FAIL reset_irqout got=%h exp=%h", irqout, e); miscompares++; end
    e = exp_q.pop_front(); vectors++;
    if (32'(led) !== e) begin $display("FAIL reset_led got=%h exp=%h", led, e); miscompares++; end
    e = exp_q.pop_front(); vectors++;
    if (32'(digi) !== e) begin $display("FAIL reset_digi got=%h exp=%h", digi, e); miscompares++; end
    reset = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        exp_q.push_back(32'h0);
        bus_read(ch_addr(c, r), got);
        e = exp_q.pop_front(); vectors++;
        if (got !== e) begin $display("FAIL reset_ch%0d_r%0d got=%h exp=%h", c, r, got, e); miscompares++; end
      end
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(32'h0);
      bus_read(A_STAT + 32'(4 * k), got);
      e = exp_q.pop_front(); vectors++;
      if (got !== e) begin $display("FAIL reset_sys%0d got=%h exp=%h", k, got, e); miscompares++; end
    end
  endtask

  task automatic test_autoreload;
    bus_write(ch_addr(0, 0), 32'hFFFF_FFFC);
    bus_write(ch_addr(0, 1), 32'hFFFF_FFFC);
    bus_write(ch_addr(0, 3), 32'h0);
    bus_write(ch_addr(0, 2), 32'h3);
    // FC, then FD FE FF, overflow back to FC on the 4th tick, then FD.
    for (int k = 1; k <= 5; k++) begin
      exp_q.push_back((k < 4) ? 32'hFFFF_FFFC + 32'(k) : 32'hFFFF_FFFC + 32'(k - 4));
      exp_q.push_back((k < 4) ? 32'h0 : 32'h1);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus_read(ch_addr(0, 1), got);
      e = exp_q.pop_front(); vectors++;
      if (got !== e) begin $display("FAIL ar_count_k%0d got=%h exp=%h", k, got, e); miscompares++; end
      e = exp_q.pop_front(); vectors++;
      if (32'(irqout) !== e) begin $display("FAIL ar_irqout_k%0d got=%h exp=%h", k, irqout, e); miscompares++; end
    end
    exp_q.push_back(32'h1);
    bus_read(A_STAT, got);
    e = exp_q.pop_front(); vectors++;
    if (got !== e) begin $display("FAIL ar_stat got=%h exp=%h", got, e); miscompares++; end
    bus_write(A_STAT, 32'h1);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    e = exp_q.pop_front(); vectors++;
    if (32'(irqout) !== e) begin $display("FAIL ar_irq_clear got=%h exp=%h", irqout, e); miscompares++; end
    bus_read(A_STAT, got);
    e = exp_q.pop_front(); vectors++;
    if (got !== e) begin $display("FAIL ar_stat_clear got=%h exp=%h", got, e); miscompares++; end
    bus_write(ch_addr(0, 2), 32'h0);
  endtask

  task automatic test_oneshot;
    bus_write(ch_addr(1, 3), 32'h2);
    bus_write(ch_addr(1, 0), 32'h10);
    bus_write(ch_addr(1, 1), 32'hFFFF_FFFF);
    bus_write(ch_addr(1, 2), 32'h5);
    // Ticks every 3rd cycle: overflow on the 3rd, then frozen with EN cleared.
    for (int k = 1; k <= 6; k++) begin
      exp_q.push_back((k < 3) ? 32'hFFFF_FFFF : 32'h10);
      exp_q.push_back((k < 3) ? 32'h5 : 32'h4);
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      bus_read(ch_addr(1, 1), got);
      e = exp_q.pop_front(); vectors++;
      if (got !== e) begin $display("FAIL os_count_k%0d got=%h exp=%h", k, got, e); miscompares++; end
      bus_read(ch_addr(1, 2), got);
      e = exp_q.pop_front(); vectors++;
      if (got !== e) begin $display("FAIL os_ctrl_k%0d got=%h exp=%h", k, got, e); miscompares++; end
    end
    exp_q.push_back(32'h0);
    bus_read(A_STAT, got);
    e = exp_q.pop_front(); vectors++;
    if (got !== e) begin $display("FAIL os_stat_noie got=%h exp=%h", got, e); miscompares++; end
  endtask

  task automatic test_w1c_race;
    bus_write(ch_addr(2, 0), 32'h0);
    bus_write(ch_addr(2, 1), 32'hFFFF_FFFE);
    bus_write(ch_addr(2, 3), 32'h0);
    bus_write(ch_addr(2, 2), 32'h3);
    @(negedge clk);
    // Clear lands on the very edge the overflow sets bit 2.
    bus_write(A_STAT, 32'h4);
    exp_q.push_back(32'h4); exp_q.push_back(32'h1);
    bus_read(A_STAT, got);
    e = exp_q.pop_front(); vectors++;
    if (got !== e) begin $display("FAIL w1c_race_stat got=%h exp=%h", got, e); miscompares++; end
    e = exp_q.pop_front(); vectors++;
    if (32'(irqout) !== e) begin $display("FAIL w1c_race_irq got=%h exp=%h", irqout, e); miscompares++; end
    bus_write(ch_addr(2, 2), 32'h0);
    bus_write(A_STAT, 32'hFFFF_FFF0);
    exp_q.push_back(32'h4);
    bus_read(A_STAT, got);
    e = exp_q.pop_front(); vectors++;
    if (got !== e) begin $display("FAIL w1c_high_bits got=%h exp=%h", got, e); miscompares++; end
    bus_write(A_STAT, 32'h4);
    exp_q.push_back(32'h0);
    bus_read(A_STAT, got);
    e = exp_q.pop_front(); vectors++;
    if (got !== e) begin $display("FAIL w1c_clear got=%h exp=%h", got, e); miscompares++; end
  endtask

  task automatic test_count_write;
    bus_write(ch_addr(3, 3), 32'h1);
    bus_write(ch_addr(3, 1), 32'h0);
    bus_write(ch_addr(3, 2), 32'h1);
    @(negedge clk);
    // This write coincides with the first tick.
    bus_write(ch_addr(3, 1), 32'h5);
    exp_q.push_back(32'h5); exp_q.push_back(32'h5); exp_q.push_back(32'h6);
    bus_read(ch_addr(3, 1), got);
    e = exp_q.pop_front(); vectors++;
    if (got !== e) begin $display("FAIL cw_written got=%h exp=%h", got, e); miscompares++; end
    @(negedge clk);
    bus_read(ch_addr(3, 1), got);
    e = exp_q.pop_front(); vectors++;
    if (got !== e) begin $display("FAIL cw_hold got=%h exp=%h", got, e); miscompares++; end
    @(negedge clk);
    bus_read(ch_addr(3, 1), got);
    e = exp_q.pop_front(); vectors++;
    if (got !== e) begin $display("FAIL cw_next_tick got=%h exp=%h", got, e); miscompares++; end
    bus_write(ch_addr(3, 2), 32'h0);
  endtask

  task automatic test_io_regs;
    sw = 8'hA5;
    exp_q.push_back(32'h00); exp_q.push_back(32'hA5);
    @(negedge clk);
    bus_read(A_SW, got);
    e = exp_q.pop_front(); vectors++;
    if (got !== e) begin $display("FAIL sw_1cyc got=%h exp=%h", got, e); miscompares++; end
    @(negedge clk);
    bus_read(A_SW, got);
    e = exp_q.pop_front(); vectors++;
    if (got !== e) begin $display("FAIL sw_2cyc got=%h exp=%h", got, e); miscompares++; end
    bus_write(A_SW, 32'h0);
    exp_q.push_back(32'hA5);
    bus_read(A_SW, got);
    e = exp_q.pop_front(); vectors++;
    if (got !== e) begin $display("FAIL sw_ro got=%h exp=%h", got, e); miscompares++; end

    bus_write(A_LED, 32'hFFFF_FF3C);
    exp_q.push_back(32'h3C); exp_q.push_back(32'h3C);
    bus_read(A_LED, got);
    e = exp_q.pop_front(); vectors++;
    if (got !== e) begin $display("FAIL led_rd got=%h exp=%h", got, e); miscompares++; end
    e = exp_q.pop_front(); vectors++;
    if (32'(led) !== e) begin $display("FAIL led_port got=%h exp=%h", led, e); miscompares++; end
    bus_write(A_DIGI, 32'h1234_5ABC);
    exp_q.push_back(32'hABC); exp_q.push_back(32'hABC);
    bus_read(A_DIGI, got);
    e = exp_q.pop_front(); vectors++;
    if (got !== e) begin $display("FAIL digi_rd got=%h exp=%h", got, e); miscompares++; end
    e = exp_q.pop_front(); vectors++;
    if (32'(digi) !== e) begin $display("FAIL digi_port got=%h exp=%h", digi, e); miscompares++; end

    bus_write(BASE + 32'h110, 32'hFFFF_FFFF);
    bus_write(BASE + 32'h40,  32'hFFFF_FFFF);
    exp_q.push_back(32'h3C); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);  exp_q.push_back(32'h0);
    bus_read(A_LED, got);
    e = exp_q.pop_front(); vectors++;
    if (got !== e) begin $display("FAIL unmapped_wr_led got=%h exp=%h", got, e); miscompares++; end
    bus_read(BASE + 32'h110, got);
    e = exp_q.pop_front(); vectors++;
    if (got !== e) begin $display("FAIL unmapped_110 got=%h exp=%h", got, e); miscompares++; end
    bus_read(BASE + 32'h40, got);
    e = exp_q.pop_front(); vectors++;
    if (got !== e) begin $display("FAIL unmapped_ch4 got=%h exp=%h", got, e); miscompares++; end
    bus_read(BASE - 32'h4, got);
    e = exp_q.pop_front(); vectors++;
    if (got !== e) begin $display("FAIL unmapped_below got=%h exp=%h", got, e); miscompares++; end
    bus_if.addr = A_LED;
    #1;
    e = exp_q.pop_front(); vectors++;
    if (bus_if.rdata !== e) begin $display("FAIL rd_low got=%h exp=%h", bus_if.rdata, e); miscompares++; end
  endtask

  task automatic test_reset_midcount;
    @(negedge clk);
    bus_write(ch_addr(0, 1), 32'hFFFF_FFFE);
    bus_write(ch_addr(0, 2), 32'h3);
    bus_write(A_LED, 32'h5A);
    bus_write(A_DIGI, 32'h123);
    exp_q.push_back(32'h1);
    e = exp_q.pop_front(); vectors++;
    if (32'(irqout) !== e) begin $display("FAIL mid_pre_irq got=%h exp=%h", irqout, e); miscompares++; end
    #2 reset = 1'b0;
    #1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    e = exp_q.pop_front(); vectors++;
    if (32'(irqout) !== e) begin $display("FAIL mid_irq got=%h exp=%h", irqout, e); miscompares++; end
    e = exp_q.pop_front(); vectors++;
    if (32'(led) !== e) begin $display("FAIL mid_led got=%h exp=%h", led, e); miscompares++; end
    e = exp_q.pop_front(); vectors++;
    if (32'(digi) !== e) begin $display("FAIL mid_digi got=%h exp=%h", digi, e); miscompares++; end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int r = 0; r < 4; r++) begin
      exp_q.push_back(32'h0);
      bus_read(ch_addr(0, r), got);
      e = exp_q.pop_front(); vectors++;
      if (got !== e) begin $display("FAIL mid_ch0_r%0d got=%h exp=%h", r, got, e); miscompares++; end
    end
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    bus_read(A_STAT, got);
    e = exp_q.pop_front(); vectors++;
    if (got !== e) begin $display("FAIL mid_stat got=%h exp=%h", got, e); miscompares++; end
    e = exp_q.pop_front(); vectors++;
    if (32'(irqout) !== e) begin $display("FAIL mid_irq_after got=%h exp=%h", irqout, e); miscompares++; end
  endtask

  initial begin
    bus_if.rd    = 1'b0;
    bus_if.wr    = 1'b0;
    bus_if.addr  = 32'h0;
    bus_if.wdata = 32'h0;
    test_reset();
    test_autoreload();
    test_oneshot();
    test_w1c_race();
    test_count_write();
    test_io_regs();
    test_reset_midcount();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
